imem_loader: RTL and testbench

- Boot-time writer for the 16-bit instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Each word is written to consecutive word addresses through the memory's write port.
- The CPU is held in reset via cpu_hold until a load completes with a good checksum.
- It sits between the host byte link (UART/JTAG bridge) and the instruction memory write port. The CPU fetch port stays read-only.

---
 rtl/imem_loader.sv | 155 +++++++++++++++
 tb/tb_imem_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed, checksummed byte
// stream into big-endian 16-bit words and releases the CPU once the load verifies.
module imem_loader #(
    parameter int ADDR_W    = 7,
    parameter int MAX_WORDS = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        arm;
    logic [15:0] len;
    logic [7:0]  word_hi;
    logic [7:0]  checksum;
    logic [15:0] frame_len;
    logic [15:0] wl_next;

    // frame_len is the complete word count as it becomes known in LEN_LO
    assign frame_len = {len[15:8], in_data};
    assign wl_next   = 16'(words_loaded) + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = in_valid && in_ready;
        arm        = 1'b0;
        case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    next_state = LEN_HI;
                    arm        = 1'b1;
                end
            end
            LEN_HI: if (accept) next_state = LEN_LO;
            LEN_LO: begin
                if (accept) begin
                    if (frame_len > 16'(MAX_WORDS)) begin
                        next_state = ERROR;
                    end else if (frame_len == 16'd0) begin
                        next_state = CHECK;
                    end else begin
                        next_state = DATA_HI;
                    end
                end
            end
            DATA_HI: if (accept) next_state = DATA_LO;
            // The count check uses the post-write value; the write itself lands next cycle
            DATA_LO: begin
                if (accept) begin
                    next_state = (wl_next == len) ? CHECK : DATA_HI;
                end
            end
            CHECK: begin
                if (accept) begin
                    next_state = (in_data == checksum) ? DONE : ERROR;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ready     <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
            len          <= '0;
            word_hi      <= '0;
        end else begin
            in_ready <= (next_state == LEN_HI) || (next_state == LEN_LO) ||
                        (next_state == DATA_HI) || (next_state == DATA_LO) ||
                        (next_state == CHECK);
            cpu_hold <= (next_state != DONE);
            done     <= (next_state == DONE);
            error    <= (next_state == ERROR);
            mem_we   <= 1'b0;

            if (arm) begin
                words_loaded <= '0;
                mem_addr     <= '0;
                checksum     <= '0;
            end

            // Advance the address after each write, pinned at the last legal word
            if (mem_we) begin
                words_loaded <= words_loaded + (ADDR_W+1)'(1);
                if (mem_addr < ADDR_W'(MAX_WORDS - 1)) begin
                    mem_addr <= mem_addr + ADDR_W'(1);
                end
            end

            if (accept) begin
                case (state)
                    LEN_HI: begin
                        len[15:8] <= in_data;
                        checksum  <= checksum + in_data;
                    end
                    LEN_LO: begin
                        len[7:0] <= in_data;
                        checksum <= checksum + in_data;
                    end
                    DATA_HI: begin
                        word_hi  <= in_data;
                        checksum <= checksum + in_data;
                    end
                    DATA_LO: begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {word_hi, in_data};
                        checksum  <= checksum + in_data;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven frames, hand-written corner
// sequences and randomized frames scored against a frame-level reference model.
module tb_imem_loader;

    localparam int ADDR_W    = 7;
    localparam int MAX_WORDS = 100;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold),
        .done(done),
        .error(error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        bit          bad;
        int          gap;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  tx_q[$];
    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    bit          m_done;
    bit          m_err;
    vec_t        vecs[9];

    // Every write pulse is recorded as {addr, data}, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_we) got_q.push_back({mem_addr, mem_wdata});
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: decodes the frame in tx_q into expected writes and outcome
    function automatic void modelFrame();
        int         n;
        logic [7:0] sum;
        exp_q.delete();
        m_done = 0;
        m_err  = 0;
        n = int'({tx_q[0], tx_q[1]});
        if (n > MAX_WORDS) begin
            m_err = 1;
            return;
        end
        for (int i = 0; i < n; i++) exp_q.push_back({7'(i), tx_q[2+2*i], tx_q[3+2*i]});
        sum = 8'd0;
        for (int i = 0; i < 2 + 2*n; i++) sum = sum + tx_q[i];
        if (tx_q[2+2*n] == sum) m_done = 1;
        else m_err = 1;
    endfunction

    function automatic void buildFrame(input int n, input bit corrupt);
        logic [7:0] sum;
        tx_q.delete();
        tx_q.push_back(8'(n >> 8));
        tx_q.push_back(8'(n));
        if (n > MAX_WORDS) return;
        for (int i = 0; i < 2*n; i++) tx_q.push_back(8'($urandom));
        sum = 8'd0;
        foreach (tx_q[i]) sum = sum + tx_q[i];
        if (corrupt) sum = sum ^ 8'($urandom_range(255, 1));
        tx_q.push_back(sum);
    endfunction

    // Streams tx_q with random idle gaps; entered and left on a falling edge
    task automatic applyStimulus(input int max_gap);
        int gap;
        int waited;
        for (int i = 0; i < tx_q.size(); i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
            in_valid = 1'b1;
            in_data  = tx_q[i];
            waited   = 0;
            while (!in_ready && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                total++;
                bad++;
                $display("[TB] FAIL byte_accept_timeout: byte %0d never accepted, in_ready=%0b required 1", i, in_ready);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic startLoad();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_hold", 32'(cpu_hold), 32'd1);
        checkOutput("start_done_clr", 32'(done), 32'd0);
        checkOutput("start_err_clr", 32'(error), 32'd0);
        checkOutput("start_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic compareLoad(input string tag);
        int nw;
        nw = exp_q.size();
        checkOutput({tag, "_wr_count"}, 32'(got_q.size()), 32'(nw));
        for (int i = 0; i < nw && i < got_q.size(); i++)
            checkOutput({tag, "_wr"}, 32'(got_q[i]), 32'(exp_q[i]));
        checkOutput({tag, "_done"}, 32'(done), 32'(m_done));
        checkOutput({tag, "_error"}, 32'(error), 32'(m_err));
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'(!m_done));
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_words"}, 32'(words_loaded), 32'(nw));
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'((nw < MAX_WORDS) ? nw : MAX_WORDS - 1));
    endtask

    task automatic runLoad(input string tag, input int max_gap);
        modelFrame();
        got_q.delete();
        startLoad();
        applyStimulus(max_gap);
        repeat (3) @(negedge clk);
        compareLoad(tag);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, "_we"}, 32'(mem_we), 32'd0);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        checkOutput({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_error"}, 32'(error), 32'd0);
        checkOutput({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        int anomalies;
        int n;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        vecs[0] = '{16'd2,     1'b0, 0, 1'b1, 1'b0, 2};
        vecs[1] = '{16'd1,     1'b1, 0, 1'b0, 1'b1, 1};
        vecs[2] = '{16'd101,   1'b0, 0, 1'b0, 1'b1, 0};
        vecs[3] = '{16'd14,    1'b0, 0, 1'b1, 1'b0, 14};
        vecs[4] = '{16'd0,     1'b0, 0, 1'b1, 1'b0, 0};
        vecs[5] = '{16'd0,     1'b1, 2, 1'b0, 1'b1, 0};
        vecs[6] = '{16'd100,   1'b0, 1, 1'b1, 1'b0, 100};
        vecs[7] = '{16'h0100,  1'b0, 0, 1'b0, 1'b1, 0};
        vecs[8] = '{16'd7,     1'b1, 5, 1'b0, 1'b1, 7};

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;

        // Idle without start: random bus noise must not provoke anything
        anomalies = 0;
        got_q.delete();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'($urandom);
            in_data  = 8'($urandom);
            @(negedge clk);
            if (mem_we || in_ready || !cpu_hold) anomalies++;
        end
        in_valid = 1'b0;
        checkOutput("idle_quiet", 32'(anomalies), 32'd0);
        checkOutput("idle_no_writes", 32'(got_q.size()), 32'd0);

        // Reference frame; the checksum covers the two length bytes too
        tx_q = '{8'h00, 8'h02, 8'h88, 8'h01, 8'hF0, 8'h00, 8'h7B};
        runLoad("ref_b2b", 0);
        checkOutput("ref_w0", 32'(got_q.size() > 0 ? got_q[0] : 23'h0), 32'({7'd0, 16'h8801}));
        checkOutput("ref_w1", 32'(got_q.size() > 1 ? got_q[1] : 23'h0), 32'({7'd1, 16'hF000}));
        runLoad("ref_gaps", 5);

        tx_q = '{8'h00, 8'h01, 8'h12, 8'h34, 8'hFF};
        runLoad("bad_sum", 0);
        checkOutput("bad_sum_w0", 32'(got_q.size() > 0 ? got_q[0] : 23'h0), 32'({7'd0, 16'h1234}));

        // Oversized length must flag error right after the second byte
        tx_q = '{8'h00, 8'h65};
        modelFrame();
        got_q.delete();
        startLoad();
        applyStimulus(0);
        checkOutput("oversize_err_now", 32'(error), 32'd1);
        repeat (3) @(negedge clk);
        compareLoad("oversize");
        buildFrame(14, 1'b0);
        runLoad("after_oversize", 2);

        foreach (vecs[v]) begin
            buildFrame(int'(vecs[v].n), vecs[v].bad);
            runLoad("table", vecs[v].gap);
            checkOutput("table_done", 32'(done), 32'(vecs[v].exp_done));
            checkOutput("table_err", 32'(error), 32'(vecs[v].exp_err));
            checkOutput("table_writes", 32'(got_q.size()), 32'(vecs[v].exp_writes));
        end

        // Reset after three of five words: partial writes stay, nothing more follows
        buildFrame(5, 1'b0);
        modelFrame();
        while (tx_q.size() > 8) void'(tx_q.pop_back());
        got_q.delete();
        startLoad();
        applyStimulus(0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("midreset");
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midreset_writes", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < got_q.size(); i++)
            checkOutput("midreset_wr", 32'(got_q[i]), 32'(exp_q[i]));
        checkOutput("midreset_idle_hold", 32'(cpu_hold), 32'd1);
        buildFrame(5, 1'b0);
        runLoad("reload", 0);

        for (int r = 0; r < 6; r++) begin
            n = ($urandom_range(7, 0) == 0) ? 100 + int'($urandom_range(40, 1)) : int'($urandom_range(20, 0));
            buildFrame(n, $urandom_range(3, 0) == 0);
            runLoad("random", int'($urandom_range(4, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
